// File: rtl/reg16_8_pkg.sv
// Shared constants and word type for the eight-entry, 16-bit JPU register file.
package reg16_8_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef logic [WIDTH-1:0] word_t;

endpackage : reg16_8_pkg

// File: rtl/reg16_word.sv
// Single register-file word: load-enabled register with synchronous active-low clear.
module reg16_word
  import reg16_8_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] word_q;
  logic [W-1:0] word_d;

  // NOTE: the default is assigned first so every path drives word_d and no latch is inferred.
  always_comb begin
    word_d = word_q;
    if (ld_i) word_d = d_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) word_q <= '0;
    else         word_q <= word_d;
  end

  assign q_o = word_q;

endmodule : reg16_word

// File: rtl/reg_16_8.sv
// Eight-entry register file, shared read/write address, registered read port O_dataA.
// Define REG16_8_WR_BYPASS_EN to forward data_in to O_dataA on a same-cycle read and write.
module reg_16_8 #(
  parameter int WIDTH  = reg16_8_pkg::WIDTH,
  parameter int DEPTH  = reg16_8_pkg::DEPTH,
  parameter int ADDR_W = reg16_8_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              enable_write,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              enable_read,
  output logic [WIDTH-1:0]  O_dataA,
  input  logic [ADDR_W-1:0] rd_wr_addr,
  input  logic              reset_n
);

  logic [DEPTH-1:0] wr_sel;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_src;
  logic [WIDTH-1:0] data_a_q;
  logic [WIDTH-1:0] data_a_d;

  // NOTE: every word is cleared by reset because software may read any register before writing it.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign wr_sel[i] = enable_write && (rd_wr_addr == ADDR_W'(i));

    reg16_word #(.W(WIDTH)) u_word (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .ld_i   (wr_sel[i]),
      .d_i    (data_in),
      .q_o    (word_q[i])
    );
  end

  assign rd_word = word_q[rd_wr_addr];

  always_comb begin
`ifdef REG16_8_WR_BYPASS_EN
    rd_src = enable_write ? data_in : rd_word;
`else
    // Same-cycle read sees the word as it was before this edge's write.
    rd_src = rd_word;
`endif
  end

  always_comb begin
    data_a_d = data_a_q;
    if (enable_read) data_a_d = rd_src;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) data_a_q <= '0;
    else          data_a_q <= data_a_d;
  end

  assign O_dataA = data_a_q;

endmodule : reg_16_8

// File: tb/tb_reg_16_8.sv
// Self-checking bench for reg_16_8: directed test-plan cases plus random traffic vs. a model.
module tb_reg_16_8;
  import reg16_8_pkg::*;

  logic        clock = 1'b0;
  logic        enable_write;
  logic [15:0] data_in;
  logic        enable_read;
  logic [15:0] O_dataA;
  logic [2:0]  rd_wr_addr;
  logic        reset_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain array of words plus the expected output register.
  word_t model_mem [8];
  word_t model_out;

  always #5 clock = ~clock;

  reg_16_8 dut (
    .clock        (clock),
    .enable_write (enable_write),
    .data_in      (data_in),
    .enable_read  (enable_read),
    .O_dataA      (O_dataA),
    .rd_wr_addr   (rd_wr_addr),
    .reset_n      (reset_n)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies one command across one rising edge, advances the model, checks O_dataA.
  task automatic step(input logic we, input logic re, input logic [2:0] addr,
                      input logic [15:0] din, input logic rn, input string tag);
    enable_write = we;
    enable_read  = re;
    rd_wr_addr   = addr;
    data_in      = din;
    reset_n      = rn;
    @(posedge clock);
    if (!rn) begin
      foreach (model_mem[k]) model_mem[k] = '0;
      model_out = '0;
    end else begin
      if (re) begin
`ifdef REG16_8_WR_BYPASS_EN
        model_out = we ? din : model_mem[addr];
`else
        model_out = model_mem[addr];
`endif
      end
      if (we) model_mem[addr] = din;
    end
    #1;
    check(tag, O_dataA, model_out);
    @(negedge clock);
  endtask

  initial begin
    logic [15:0] simul_exp;
    enable_write = 1'b0;
    enable_read  = 1'b0;
    rd_wr_addr   = '0;
    data_in      = '0;
    reset_n      = 1'b0;
    foreach (model_mem[k]) model_mem[k] = '0;
    model_out = '0;
    @(negedge clock);

    // Reset held two cycles, strobes active to confirm reset overrides them.
    step(1'b1, 1'b1, 3'd4, 16'hDEAD, 1'b0, "reset_0");
    check("reset_lit0", O_dataA, 16'h0000);
    step(1'b0, 1'b1, 3'd4, 16'h0000, 1'b0, "reset_1");
    check("reset_lit1", O_dataA, 16'h0000);
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, 1'b1, 3'(i), 16'h0000, 1'b1, "reset_read");
      check("reset_read_lit", O_dataA, 16'h0000);
    end

    // Write 0xFF31 to address 1 for five cycles, then read it back and hold.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd1, 16'hFF31, 1'b1, "wr_ff31");
    step(1'b0, 1'b1, 3'd1, 16'h0000, 1'b1, "rd_ff31");
    check("rd_ff31_lit", O_dataA, 16'hFF31);
    step(1'b0, 1'b0, 3'd5, 16'h0000, 1'b1, "hold_ff31");
    check("hold_ff31_lit", O_dataA, 16'hFF31);

    // Hold while writing a new value, then the next read returns it.
    step(1'b1, 1'b0, 3'd1, 16'hABCD, 1'b1, "hold_wr");
    check("hold_wr_lit", O_dataA, 16'hFF31);
    step(1'b0, 1'b1, 3'd1, 16'h0000, 1'b1, "rd_abcd");
    check("rd_abcd_lit", O_dataA, 16'hABCD);

    // Full sweep, read back in reverse order.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'(i), 16'h1000 + 16'(i), 1'b1, "sweep_wr");
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, 1'b1, 3'(i), 16'h0000, 1'b1, "sweep_rd");
      check("sweep_rd_lit", O_dataA, 16'h1000 + 16'(i));
    end

    // Simultaneous read and write on address 2.
    step(1'b1, 1'b0, 3'd2, 16'h1111, 1'b1, "simul_pre");
    step(1'b1, 1'b1, 3'd2, 16'h2222, 1'b1, "simul");
`ifdef REG16_8_WR_BYPASS_EN
    simul_exp = 16'h2222;
`else
    simul_exp = 16'h1111;
`endif
    check("simul_lit", O_dataA, simul_exp);
    step(1'b0, 1'b1, 3'd2, 16'h0000, 1'b1, "simul_after");
    check("simul_after_lit", O_dataA, 16'h2222);

    // Write during reset is discarded.
    step(1'b1, 1'b0, 3'd3, 16'h5A5A, 1'b0, "mid_rst");
    step(1'b0, 1'b1, 3'd3, 16'h0000, 1'b1, "mid_rst_rd");
    check("mid_rst_rd_lit", O_dataA, 16'h0000);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           16'($urandom), ($urandom_range(0, 31) != 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reg_16_8
